// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter shared by instruction fetch and load/store.
// Data requests win by default. Fetch is forced after MAX_STREAK consecutive
// data grants while fetch is waiting. Each read is tracked by a tag that
// travels alongside the BRAM latency. The tag routes and formats the response.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 14,
  parameter int MAX_STREAK  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_req_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [31:0]       d_req_addr,
  input  logic              d_req_we,
  input  logic [2:0]        d_req_funct3,
  input  logic [31:0]       d_req_wdata,
  output logic              d_resp_valid,
  output logic [31:0]       d_resp_data,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  typedef enum logic {SRC_IF = 1'b0, SRC_D = 1'b1} src_e;

  typedef struct packed {
    logic       valid;
    src_e       src;
    logic [2:0] funct3;
    logic [1:0] off;
  } tag_t;

  logic [STREAK_W-1:0] streak;
  logic                grant_d;
  logic                grant_f;
  logic                d_legal;
  logic                d_read;
  logic                d_store;
  logic [1:0]          d_off;
  logic [3:0]          store_we;
  logic [31:0]         store_wdata;
  tag_t                tag_in;
  tag_t                tag_out;
  tag_t                tag_pipe [MEM_LATENCY];
  logic [31:0]         shifted;
  logic [31:0]         load_data;
  logic                unused_addr_bits;

  // The arbiter only ever looks at the word-address bits of the fetch address.
  assign unused_addr_bits = ^{if_req_addr[31:ADDR_W+2], if_req_addr[1:0],
                              d_req_addr[31:ADDR_W+2]};

  assign d_off = d_req_addr[1:0];

  // Pick this cycle's winner. Nothing is granted while reset is held.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (!rst_in) begin
      grant_d = d_req_valid && !(if_req_valid && streak == STREAK_W'(MAX_STREAK));
      grant_f = if_req_valid && !grant_d;
    end
  end

  assign if_req_ready = grant_f;
  assign d_req_ready  = grant_d;

  // Legal funct3 for the access direction, plus natural alignment.
  always_comb begin
    d_legal = 1'b0;
    case (d_req_funct3)
      3'b000:  d_legal = 1'b1;
      3'b001:  d_legal = ~d_off[0];
      3'b010:  d_legal = (d_off == 2'b00);
      3'b100:  d_legal = ~d_req_we;
      3'b101:  d_legal = ~d_req_we & ~d_off[0];
      default: d_legal = 1'b0;
    endcase
  end

  // Byte-lane enables and store data replicated across the lanes.
  always_comb begin
    store_we    = 4'b0000;
    store_wdata = d_req_wdata;
    case (d_req_funct3[1:0])
      2'b00: begin
        store_we    = 4'b0001 << d_off;
        store_wdata = {4{d_req_wdata[7:0]}};
      end
      2'b01: begin
        store_we    = 4'b0011 << d_off;
        store_wdata = {2{d_req_wdata[15:0]}};
      end
      2'b10:   store_we = 4'b1111;
      default: store_we = 4'b0000;
    endcase
  end

  assign d_read  = grant_d && d_legal && !d_req_we;
  assign d_store = grant_d && d_legal && d_req_we;

  // Drive the BRAM port from the granted request. An illegal data request
  // consumes the grant but leaves the port idle.
  always_comb begin
    mem_en    = grant_f || (grant_d && d_legal);
    mem_we    = d_store ? store_we : 4'b0000;
    mem_wdata = d_store ? store_wdata : 32'h0;
    mem_addr  = '0;
    if (grant_f)
      mem_addr = if_req_addr[ADDR_W+1:2];
    else if (grant_d && d_legal)
      mem_addr = d_req_addr[ADDR_W+1:2];
  end

  // Count data grants that keep a waiting fetch out. Saturate at the limit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst_in)
      streak <= '0;
    else if (!if_req_valid || grant_f)
      streak <= '0;
    else if (grant_d && streak != STREAK_W'(MAX_STREAK))
      streak <= streak + 1'b1;
  end

  always_comb begin
    tag_in        = '0;
    tag_in.valid  = grant_f || d_read;
    tag_in.src    = grant_f ? SRC_IF : SRC_D;
    tag_in.funct3 = d_req_funct3;
    tag_in.off    = d_off;
  end

  // Tag pipeline runs every cycle, carrying bubbles when no read issues.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: the tag stages are reset because a stale valid bit would emit a phantom response; a data-only storage array would not need this.
    if (rst_in) begin
      for (int i = 0; i < MEM_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < MEM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[MEM_LATENCY-1];
  assign shifted = mem_rdata >> {tag_out.off, 3'b000};

  // Format load data according to the size and signedness held in the tag.
  always_comb begin
    load_data = mem_rdata;
    case (tag_out.funct3)
      3'b000:  load_data = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // Register the responses and the error pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      if_resp_valid <= 1'b0;
      if_resp_data  <= 32'h0;
      d_resp_valid  <= 1'b0;
      d_resp_data   <= 32'h0;
      d_err         <= 1'b0;
    end else begin
      if_resp_valid <= tag_out.valid && tag_out.src == SRC_IF;
      d_resp_valid  <= tag_out.valid && tag_out.src == SRC_D;
      d_err         <= grant_d && !d_legal;
      if (tag_out.valid && tag_out.src == SRC_IF) if_resp_data <= mem_rdata;
      if (tag_out.valid && tag_out.src == SRC_D)  d_resp_data  <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A byte-level reference memory and the
// arbitration rules predict grants, port drive and responses. A monitor
// checks the response ports against queued expectations every cycle.
module tb_mem_port_arbiter;

  localparam int L    = 2;
  localparam int AW   = 14;
  localparam int MAXS = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          if_req_valid = 1'b0;
  logic          if_req_ready;
  logic [31:0]   if_req_addr = '0;
  logic          if_resp_valid;
  logic [31:0]   if_resp_data;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic [31:0]   d_req_addr = '0;
  logic          d_req_we = 1'b0;
  logic [2:0]    d_req_funct3 = '0;
  logic [31:0]   d_req_wdata = '0;
  logic          d_resp_valid;
  logic [31:0]   d_resp_data;
  logic          d_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(AW), .MAX_STREAK(MAXS)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_funct3(d_req_funct3), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Fixed-latency BRAM model, loaded with word = byte address.
  logic [31:0] bram [1024];
  logic [31:0] rd_pipe [L];
  bit          bram_loaded = 1'b0;
  assign mem_rdata = rd_pipe[L-1];

  always @(posedge clk_in) begin
    if (!bram_loaded) begin
      for (int i = 0; i < 1024; i++) bram[i] <= i * 4;
      for (int i = 0; i < L; i++) rd_pipe[i] <= '0;
      bram_loaded <= 1'b1;
    end else begin
      for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= 32'hDEAD_BEEF;
      if (mem_en) begin
        if (mem_we != 4'b0000) begin
          for (int b = 0; b < 4; b++)
            if (mem_we[b]) bram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
          rd_pipe[0] <= bram[mem_addr[9:0]];
        end
      end
    end
  end

  // Reference model state.
  logic [7:0] ref_bytes [4096];
  int         streak_m = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];
  int   err_q[$];

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (we) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return ok && ((a % size_of(f3)) == 0);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    int base;
    base = {20'h0, a[11:2], 2'b00};
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_bytes[base + i];
    return w;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] r;
    int sz;
    int base;
    sz   = size_of(f3);
    base = {20'h0, a[11:0]};
    r    = '0;
    for (int i = 0; i < sz; i++) r[8*i +: 8] = ref_bytes[base + i];
    if (!f3[2] && sz < 4 && ref_bytes[base + sz - 1][7])
      for (int i = sz; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // One clock of stimulus. Inputs change just after the edge. The port is
  // judged at the falling edge, and expected responses are queued.
  task automatic step(input bit fv, input logic [31:0] fa, input bit dv,
                      input logic [31:0] da, input bit we, input logic [2:0] f3,
                      input logic [31:0] wd, output string g);
    bit exp_d, exp_f, ok;
    int sz, off, base;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
    @(posedge clk_in);
    #1;
    if_req_valid = fv;  if_req_addr = fa;
    d_req_valid  = dv;  d_req_addr  = da;
    d_req_we     = we;  d_req_funct3 = f3;  d_req_wdata = wd;
    @(negedge clk_in);
    exp_d = dv && !(fv && streak_m == MAXS);
    exp_f = fv && !exp_d;
    ok    = is_legal(we, f3, da);
    g     = exp_d ? "D" : (exp_f ? "F" : "-");
    check("if_req_ready", if_req_ready, exp_f);
    check("d_req_ready", d_req_ready, exp_d);
    check("mem_en", mem_en, exp_f || (exp_d && ok));
    if (exp_f) begin
      check("mem_addr_fetch", mem_addr, fa[AW+1:2]);
      check("mem_we_fetch", mem_we, 4'b0000);
      if_q.push_back('{word_at(fa), cyc + L + 1});
    end else if (exp_d && ok) begin
      check("mem_addr_data", mem_addr, da[AW+1:2]);
      if (we) begin
        sz   = size_of(f3);
        off  = da[1:0];
        base = {20'h0, da[11:2], 2'b00};
        for (int b = 0; b < 4; b++) begin
          exp_we[b]        = (b >= off) && (b < off + sz);
          exp_wd[8*b +: 8] = wd[8*(b % sz) +: 8];
        end
        check("mem_we_store", mem_we, exp_we);
        check("mem_wdata_store", mem_wdata, exp_wd);
        for (int b = 0; b < 4; b++)
          if (exp_we[b]) ref_bytes[base + b] = exp_wd[8*b +: 8];
      end else begin
        check("mem_we_load", mem_we, 4'b0000);
        d_q.push_back('{load_value(f3, da), cyc + L + 1});
      end
    end else begin
      check("mem_we_idle", mem_we, 4'b0000);
      if (exp_d) err_q.push_back(cyc + 1);
    end
    if (!fv || exp_f)                    streak_m = 0;
    else if (exp_d && streak_m < MAXS)   streak_m++;
  endtask

  task automatic idle(input int n);
    string g;
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, g);
  endtask

  task automatic check_outputs_zero();
    check("rst_if_req_ready", if_req_ready, 0);
    check("rst_d_req_ready", d_req_ready, 0);
    check("rst_if_resp_valid", if_resp_valid, 0);
    check("rst_if_resp_data", if_resp_data, 0);
    check("rst_d_resp_valid", d_resp_valid, 0);
    check("rst_d_resp_data", d_resp_data, 0);
    check("rst_d_err", d_err, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
  endtask

  // Response monitor: each expectation must appear exactly on its due cycle.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (if_q.size() > 0 && if_q[0].due == cyc) begin
        check("if_resp_valid", if_resp_valid, 1);
        check("if_resp_data", if_resp_data, if_q[0].data);
        void'(if_q.pop_front());
      end else begin
        check("if_resp_idle", if_resp_valid, 0);
      end
      if (d_q.size() > 0 && d_q[0].due == cyc) begin
        check("d_resp_valid", d_resp_valid, 1);
        check("d_resp_data", d_resp_data, d_q[0].data);
        void'(d_q.pop_front());
      end else begin
        check("d_resp_idle", d_resp_valid, 0);
      end
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        check("d_err_pulse", d_err, 1);
        void'(err_q.pop_front());
      end else begin
        check("d_err_idle", d_err, 0);
      end
    end
  end

  initial begin
    string g;
    string seq;
    for (int a = 0; a < 4096; a++) begin
      logic [31:0] w;
      w = a & ~3;
      ref_bytes[a] = w[8*(a % 4) +: 8];
    end

    // Reset state with both requesters asking.
    if_req_valid = 1; d_req_valid = 1; d_req_addr = 32'h4; d_req_we = 1; d_req_funct3 = 3'd2;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_outputs_zero();
    @(posedge clk_in);
    #1;
    rst_in = 0; if_req_valid = 0; d_req_valid = 0; d_req_we = 0;

    // Back-to-back fetches.
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 4 * i, 0, 0, 0, 0, 0, g);
    idle(L + 2);

    // Both requesters valid: fetch is forced after MAXS data grants.
    seq = "";
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h200 + 4 * i, 1, 32'h300 + 4 * i, 0, 3'd2, 0, g);
      seq = {seq, g};
    end
    check_str("grant_order", seq, "DDDDFDDDDF");
    idle(L + 2);

    // Stores: SB, SH, SW, followed by read-back.
    step(0, 0, 1, 32'h3, 1, 3'd0, 32'h0000_00A5, g);
    step(0, 0, 1, 32'h2, 1, 3'd1, 32'h0000_BEEF, g);
    step(0, 0, 1, 32'h8, 1, 3'd2, 32'h1234_5678, g);
    step(0, 0, 1, 32'h0, 0, 3'd2, 0, g);
    step(0, 0, 1, 32'h8, 0, 3'd2, 0, g);
    idle(L + 2);

    // Load extension from 0x80F07F81.
    step(0, 0, 1, 32'h40, 1, 3'd2, 32'h80F0_7F81, g);
    step(0, 0, 1, 32'h40, 0, 3'd0, 0, g);
    step(0, 0, 1, 32'h40, 0, 3'd4, 0, g);
    step(0, 0, 1, 32'h42, 0, 3'd1, 0, g);
    step(0, 0, 1, 32'h42, 0, 3'd5, 0, g);
    step(0, 0, 1, 32'h41, 0, 3'd4, 0, g);
    step(0, 0, 1, 32'h43, 0, 3'd0, 0, g);
    idle(L + 2);

    // Illegal requests: a misaligned LW alongside a waiting fetch, and bad funct3.
    step(1, 32'h500, 1, 32'h2, 0, 3'd2, 0, g);
    step(1, 32'h500, 0, 0, 0, 0, 0, g);
    check_str("fetch_after_err", g, "F");
    step(0, 0, 1, 32'h10, 0, 3'd3, 0, g);
    step(0, 0, 1, 32'h10, 1, 3'd4, 0, g);
    idle(L + 2);

    // Reset while two loads are in flight.
    step(0, 0, 1, 32'h40, 0, 3'd2, 0, g);
    step(0, 0, 1, 32'h44, 0, 3'd2, 0, g);
    @(posedge clk_in);
    #1;
    rst_in = 1;
    if_req_valid = 1; d_req_valid = 1; d_req_we = 1;
    if_q.delete(); d_q.delete(); err_q.delete();
    streak_m = 0;
    @(negedge clk_in);
    check_outputs_zero();
    @(posedge clk_in);
    #1;
    rst_in = 0; if_req_valid = 0; d_req_valid = 0; d_req_we = 0;
    idle(L + 3);
    step(1, 32'h600, 0, 0, 0, 0, 0, g);
    idle(L + 2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
           $urandom_range(0, 3) != 0, 32'($urandom_range(0, 4095)),
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom, g);
    end
    idle(L + 3);

    check("if_queue_drained", if_q.size(), 0);
    check("d_queue_drained", d_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
